if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction fetch stage sitting directly upstream of the combinational instruction memory.
- Owns the program counter and drives the fetch address to the memory.
- Captures the returned instruction word into the IF/ID pipeline register for the decoder.
- Supports pipeline stall, branch/jump redirect with flush, and a retired-fetch counter for performance monitoring.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0013: bubble encoding (addi x0,x0,0) placed in IF/ID on reset and flush.
- CNT_WIDTH, 32: width of the fetch counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- redirect  input  1  branch/jump taken; load new PC and flush IF/ID.
- redirect_target  input  32  byte address of the redirect destination.
- imem_addr  output  32  fetch address to the instruction memory; equals pc.
- imem_instr  input  32  instruction word returned combinationally by the memory for imem_addr.
- pc  output  32  current program counter (registered).
- id_pc  output  32  PC of the instruction held in IF/ID.
- id_instr  output  32  instruction held in IF/ID.
- id_valid  output  1  IF/ID holds a real instruction (not a bubble).
- fetch_count  output  CNT_WIDTH  number of instructions accepted into IF/ID since reset.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset).
- Reset (sampled at a rising edge with reset=1) overrides all other inputs:
  - pc <= RESET_PC
  - id_pc <= 0
  - id_instr <= NOP_INSTR
  - id_valid <= 0
  - fetch_count <= 0
- imem_addr is a pure wire copy of pc. The memory is combinational, so imem_instr is valid in the same cycle. No wait states.
- Per rising edge with reset=0, exactly one case applies, in priority order:
  1. redirect=1 (wins over stall):
     - pc <= {redirect_target[31:2], 2'b00}; the low two bits are forced to zero and no fault is raised.
     - id_instr <= NOP_INSTR, id_valid <= 0, id_pc <= 0.
     - fetch_count unchanged.
     - The instruction currently being fetched is discarded.
  2. stall=1:
     - pc, id_pc, id_instr, id_valid and fetch_count all hold.
     - imem_addr stays stable, so the same word is re-presented.
  3. Otherwise (advance):
     - id_instr <= imem_instr, id_pc <= pc, id_valid <= 1.
     - pc <= pc + 4, computed modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
     - fetch_count <= fetch_count + 1, wrapping modulo 2^CNT_WIDTH.
- Latency: an instruction at address A appears on id_instr/id_pc with id_valid=1 one clock after pc=A with no stall or redirect.
- Throughput: one instruction per cycle when unstalled.
- After a redirect to T: id_valid=0 for one cycle, then T's instruction appears in IF/ID on the next advancing edge.
- Redirect asserted on consecutive cycles: each takes effect. The last target wins, and id_valid stays 0 throughout.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge. No state from before reset is retained.
- All outputs except imem_addr are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then run: reset high for 2 cycles, RESET_PC=0, memory words 0x00500093 @0 and 0x00A00113 @4, no stall → cycle 1 id_valid=1, id_pc=0, id_instr=0x00500093; cycle 2 id_pc=4, id_instr=0x00A00113; pc=8, fetch_count=2.
- Stall hold: pc=0x10, assert stall for 3 cycles → pc, id_pc, id_instr, id_valid and fetch_count all unchanged; imem_addr=0x10 throughout. Release → next edge gives id_pc=0x10, pc=0x14.
- Redirect flush: pc=0x20, redirect=1, target=0x40 → next edge gives pc=0x40, id_valid=0, id_instr=0x00000013, fetch_count unchanged. Following edge gives id_pc=0x40, id_valid=1.
- Redirect vs stall: stall=1 and redirect=1 with target=0x83 on the same edge → pc=0x80, id_valid=0 (redirect wins, low bits cleared).
- Wrap-around: force pc to 0xFFFF_FFFC, advance → pc=0x0000_0000, id_pc=0xFFFF_FFFC. With CNT_WIDTH=4, 16 advances from reset → fetch_count returns to 0.
- Reset mid-operation: after 5 fetches, assert reset together with stall=1 → next edge gives pc=RESET_PC, id_valid=0, id_instr=0x00000013, fetch_count=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage feeding a combinational instruction memory. Owns the
// program counter, presents it as the fetch address and captures the returned
// word into the IF/ID pipeline register. Supports stall, branch/jump redirect
// with flush and a retired-fetch counter.
//
// Ports:
//   clk              system clock, all state updates on the rising edge
//   reset            synchronous active-high reset
//   stall            hold PC and IF/ID this cycle
//   redirect         branch/jump taken: load redirect_target and flush IF/ID
//   redirect_target  byte address of the redirect destination
//   imem_addr        fetch address to instruction memory (copy of pc)
//   imem_instr       instruction word returned combinationally for imem_addr
//   pc               current program counter
//   id_pc            PC of the instruction held in IF/ID
//   id_instr         instruction held in IF/ID
//   id_valid         IF/ID holds a real instruction rather than a bubble
//   fetch_count      instructions accepted into IF/ID since reset
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_target,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_instr,
  output logic [31:0]          pc,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_instr,
  output logic                 id_valid,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  logic [31:0]          pc_q, pc_d;
  logic [31:0]          id_pc_q, id_pc_d;
  logic [31:0]          id_instr_q, id_instr_d;
  logic                 id_valid_q, id_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Priority: redirect, then stall, then advance. Reset is handled in the
  // register process so it overrides everything.
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    cnt_d      = cnt_q;
    if (redirect) begin
      // Misaligned targets are silently aligned down; the in-flight fetch is dropped.
      pc_d       = {redirect_target[31:2], 2'b00};
      id_pc_d    = 32'h0;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d       = pc_q + 32'd4;
      id_pc_d    = pc_q;
      id_instr_d = imem_instr;
      id_valid_d = 1'b1;
      cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign id_pc       = id_pc_q;
  assign id_instr    = id_instr_q;
  assign id_valid    = id_valid_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_target;

  logic [31:0] imem_addr, imem_instr, pc, id_pc, id_instr;
  logic        id_valid;
  logic [31:0] fetch_count;

  logic [31:0] s_imem_addr, s_imem_instr, s_pc, s_id_pc, s_id_instr;
  logic        s_id_valid;
  logic [3:0]  s_fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory model: two fixed words, an address-tagged pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h0050_0093;
      32'h4:   mem_word = 32'h00A0_0113;
      default: mem_word = {a[15:0], 16'h1337};
    endcase
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign s_imem_instr = mem_word(s_imem_addr);

  if_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .pc              (pc),
    .id_pc           (id_pc),
    .id_instr        (id_instr),
    .id_valid        (id_valid),
    .fetch_count     (fetch_count)
  );

  if_fetch_stage #(.CNT_WIDTH(4)) dut_small (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (s_imem_addr),
    .imem_instr      (s_imem_instr),
    .pc              (s_pc),
    .id_pc           (s_id_pc),
    .id_instr        (s_id_instr),
    .id_valid        (s_id_valid),
    .fetch_count     (s_fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_idpc,
                           input logic [31:0] e_instr, input logic e_valid,
                           input logic [31:0] e_cnt);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".imem_addr"}, imem_addr, e_pc);
    chk({tag, ".id_pc"}, id_pc, e_idpc);
    chk({tag, ".id_instr"}, id_instr, e_instr);
    chk({tag, ".id_valid"}, {31'h0, id_valid}, {31'h0, e_valid});
    chk({tag, ".fetch_count"}, fetch_count, e_cnt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    step();
    step();
    chk_state("reset", 32'h0, 32'h0, Nop, 1'b0, 32'd0);

    // Reset then run
    reset = 1'b0;
    step();
    chk_state("run1", 32'h4, 32'h0, 32'h0050_0093, 1'b1, 32'd1);
    step();
    chk_state("run2", 32'h8, 32'h4, 32'h00A0_0113, 1'b1, 32'd2);
    step();
    step();
    chk_state("run4", 32'h10, 32'hC, 32'h000C_1337, 1'b1, 32'd4);

    // Stall hold for three cycles, then release
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("stall", 32'h10, 32'hC, 32'h000C_1337, 1'b1, 32'd4);
    end
    stall = 1'b0;
    step();
    chk_state("release", 32'h14, 32'h10, 32'h0010_1337, 1'b1, 32'd5);

    // Redirect flush from pc=0x20
    step(); step(); step();
    chk({"pre_redir.pc"}, pc, 32'h20);
    redirect = 1'b1; redirect_target = 32'h40;
    step();
    redirect = 1'b0;
    chk_state("redir", 32'h40, 32'h0, Nop, 1'b0, 32'd8);
    step();
    chk_state("post_redir", 32'h44, 32'h40, 32'h0040_1337, 1'b1, 32'd9);

    // Redirect beats stall; low target bits cleared
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h83;
    step();
    chk_state("redir_stall", 32'h80, 32'h0, Nop, 1'b0, 32'd9);

    // Back-to-back redirects: last target wins, bubble persists
    stall = 1'b0; redirect_target = 32'h100;
    step();
    chk_state("redir_a", 32'h100, 32'h0, Nop, 1'b0, 32'd9);
    redirect_target = 32'h207;
    step();
    chk_state("redir_b", 32'h204, 32'h0, Nop, 1'b0, 32'd9);

    // PC wrap-around
    redirect_target = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk({"wrap_pre.pc"}, pc, 32'hFFFF_FFFC);
    step();
    chk_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'hFFFC_1337, 1'b1, 32'd10);

    // 4-bit counter wraps after 16 fetches from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("small_rst.fetch_count", {28'h0, s_fetch_count}, 32'd0);
    for (int i = 0; i < 15; i++) step();
    chk("small15.fetch_count", {28'h0, s_fetch_count}, 32'd15);
    step();
    chk("small16.fetch_count", {28'h0, s_fetch_count}, 32'd0);
    chk("big16.fetch_count", fetch_count, 32'd16);
    chk("small16.pc", s_pc, 32'h40);

    // Reset mid-operation, together with stall and redirect
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_state("five", 32'h14, 32'h10, 32'h0010_1337, 1'b1, 32'd5);
    reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_target = 32'h300;
    step();
    chk_state("reset_mid", 32'h0, 32'h0, Nop, 1'b0, 32'd0);
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    step();
    chk_state("after_reset", 32'h4, 32'h0, 32'h0050_0093, 1'b1, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
